// File: rtl/key_press_classifier.sv
// -----------------------------------------------------------------------------
// key_press_classifier
//
// Front end for one push button. It synchronises the raw active-low KEY input,
// debounces it, and classifies each debounced press as either a short press
// (reported on release) or a long press (reported while the button is still
// held). One instance is used per KEY bit; key_control uses state[1] to enter
// adjust mode and state[0] for everything else.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level change
//   LONG_CYCLES      debounced hold length that qualifies as a long press
//   REPEAT_CYCLES    auto-repeat period after a long press (auto-repeat only)
//
// Ports
//   CLOCK_50  in   1  system clock, all logic on posedge
//   rst       in   1  synchronous reset, active-high
//   key       in   1  raw push button, asynchronous, active-low (0 = pressed)
//   state     out  2  [0] short-press pulse, [1] long-press pulse, one cycle each
//   pressed   out  1  debounced level, 1 while the button is considered held
//
// Build option
//   KEY_AUTO_REPEAT_EN  when defined, holding past a long press emits a
//                       state[0] pulse every REPEAT_CYCLES cycles until release.
//                       When undefined the repeat counter does not exist and
//                       REPEAT_CYCLES only takes part in parameter validation.
// -----------------------------------------------------------------------------
module key_press_classifier #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       key,
  output logic [1:0] state,
  output logic       pressed
);

  // ---------------------------------------------------------------------------
  // Parameter validation. Glitch rejection needs at least two stable cycles,
  // and a zero-length hold or repeat period would make the counters meaningless.
  // ---------------------------------------------------------------------------
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_press_classifier: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("key_press_classifier: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("key_press_classifier: REPEAT_CYCLES must be >= 1");
  end

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Both flops reset to 1 (button released) so a reset
  // never looks like a press. Only ks_q is used downstream.
  // ---------------------------------------------------------------------------
  logic key_meta_q;
  logic ks_q;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      key_meta_q <= 1'b1;
      ks_q       <= 1'b1;
    end else begin
      key_meta_q <= key;
      ks_q       <= key_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer. db_cnt counts consecutive cycles in which the synchronised
  // level disagrees with the accepted level; any agreement clears it. After
  // DEBOUNCE_CYCLES disagreeing cycles the accepted level flips.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pressed_q, pressed_d;
  logic            ks_active;   // synchronised key, active-high
  logic            db_flip;     // accepted level changes on this edge
  logic            press_evt;   // accepted level goes released -> pressed

  assign ks_active = ~ks_q;

  always_comb begin
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    db_flip   = 1'b0;
    if (ks_active == pressed_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_flip   = 1'b1;
      pressed_d = ~pressed_q;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  assign press_evt = db_flip & ~pressed_q;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      db_cnt_q  <= '0;
      pressed_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press classifier FSM.
  //
  // HELD is entered on the same edge that the debounced level rises, so
  // hold_cnt equals the number of cycles pressed has been high minus one and
  // the long pulse lands exactly LONG_CYCLES cycles after pressed rises.
  // Release is detected from the registered level, so the short pulse appears
  // in the cycle after pressed falls. Release has priority over the long
  // threshold: a press whose debounced level is already gone is short.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        state_q, state_d;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  always_comb begin
    fsm_d      = fsm_q;
    hold_cnt_d = hold_cnt_q;
    state_d    = 2'b00;
`ifdef KEY_AUTO_REPEAT_EN
    rpt_cnt_d  = rpt_cnt_q;
`endif

    case (fsm_q)
      IDLE: begin
        if (press_evt) begin
          fsm_d      = HELD;
          hold_cnt_d = '0;
        end
      end

      HELD: begin
        // Saturating count: a stuck button must never wrap back to zero.
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
        if (!pressed_q) begin
          state_d = 2'b01;
          fsm_d   = IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = 2'b10;
          fsm_d   = LONG;
`ifdef KEY_AUTO_REPEAT_EN
          rpt_cnt_d = '0;
`endif
        end
      end

      LONG: begin
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
        if (!pressed_q) begin
          // Release after a long press is silent.
          fsm_d = IDLE;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (rpt_cnt_q == RPT_LAST) begin
          state_d   = 2'b01;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_ONE;
        end
`endif
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      fsm_q      <= IDLE;
      hold_cnt_q <= '0;
      state_q    <= 2'b00;
    end else begin
      fsm_q      <= fsm_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`endif

  // Outputs come straight from flops: no combinational path from key.
  assign state   = state_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_key_press_classifier
//
// Drives key-press transactions (directed boundaries plus random lengths) into
// key_press_classifier with small timing parameters. For each transaction the
// expected pressed edges and state pulses are computed from the press length
// and pushed, time-stamped, into a scoreboard queue. An independent monitor
// pops and compares whenever pressed changes or a state bit is set.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_press_classifier;

  localparam int D  = 4;   // DEBOUNCE_CYCLES
  localparam int LC = 20;  // LONG_CYCLES
  localparam int RC = 8;   // REPEAT_CYCLES

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_LONG  = 2;
  localparam int K_SHORT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [1:0] state;
  logic       pressed;

  key_press_classifier #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (LC),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .CLOCK_50(clk),
    .rst     (rst),
    .key     (key),
    .state   (state),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  // Number of the most recent rising edge; stable at the falling edge.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int cyc;
    int kind;
  } evt_t;

  evt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  logic prev_pressed = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "press_rise";
      K_FALL:  return "press_fall";
      K_LONG:  return "long_pulse";
      default: return "short_pulse";
    endcase
  endfunction

  // Keep the queue ordered by cycle, and within a cycle in the order the
  // monitor inspects outputs (pressed edge, long, short).
  function automatic void push_evt(input int c, input int k);
    evt_t e;
    int   i;
    e.cyc  = c;
    e.kind = k;
    i = exp_q.size();
    while (i > 0 && (exp_q[i-1].cyc > c || (exp_q[i-1].cyc == c && exp_q[i-1].kind > k)))
      i--;
    exp_q.insert(i, e);
  endfunction

  // Reference model of one press: key sampled low on edges c0 .. c0+len-1,
  // high for at least D cycles afterwards, classifier idle beforehand.
  // The synchroniser costs 2 edges and the debouncer D more, so pressed is
  // high from edge c0+1+D for exactly len cycles (if len >= D at all).
  function automatic void model_press(input int c0, input int len);
    int p;
    int f;
    int q;
    if (len < D) return;
    p = c0 + 1 + D;
    f = p + len;
    push_evt(p, K_RISE);
    push_evt(f, K_FALL);
    if (len >= LC) begin
      q = p + LC;
      push_evt(q, K_LONG);
`ifdef KEY_AUTO_REPEAT_EN
      for (int t = q + RC; t <= f; t += RC) push_evt(t, K_SHORT);
`endif
    end else begin
      push_evt(f + 1, K_SHORT);
    end
  endfunction

  function automatic void check_evt(input int k);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required no event", kname(k), edge_n);
      return;
    end
    e = exp_q.pop_front();
    if (e.cyc != edge_n || e.kind != k) begin
      errors++;
      $display("FAIL event_match: got %s at cycle %0d, required %s at cycle %0d",
               kname(k), edge_n, kname(e.kind), e.cyc);
    end
  endfunction

  // Monitor: independent of stimulus, samples on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        checks++;
        errors++;
        $display("FAIL missing_event: got nothing by cycle %0d, required %s at cycle %0d",
                 edge_n, kname(exp_q[0].kind), exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (pressed !== prev_pressed) check_evt(pressed ? K_RISE : K_FALL);
      if (state[1] === 1'b1) check_evt(K_LONG);
      if (state[0] === 1'b1) check_evt(K_SHORT);
      checks++;
      if (state === 2'b11) begin
        errors++;
        $display("FAIL pulse_exclusive: got state=%b at cycle %0d, required not 11", state, edge_n);
      end
    end
    prev_pressed = pressed;
  end

  task automatic check_idle(input string name);
    checks++;
    if (state !== 2'b00 || pressed !== 1'b0) begin
      errors++;
      $display("FAIL %s: got state=%b pressed=%b, required state=00 pressed=0", name, state, pressed);
    end
  endtask

  // Call at a falling edge; returns at a falling edge.
  task automatic do_press(input int len, input int gap, input string name);
    int c0;
    c0 = edge_n + 1;
    model_press(c0, len);
    $display("txn %s: key low %0d cycles from cycle %0d, then high %0d cycles", name, len, c0, gap);
    key = 1'b0;
    repeat (len) @(negedge clk);
    key = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int p;
    int e;
    int len;
    int gap;

    // Reset with the key held: outputs must stay idle for every reset cycle.
    rst = 1'b1;
    key = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("reset_state");
    end
    $display("txn reset: rst high 3 cycles with key low");
    rst    = 1'b0;
    mon_en = 1'b1;
    // Key already low: the press starts on the first edge out of reset.
    do_press(10, 10, "after_reset_short");

    do_press(D - 1, 8, "glitch");
    do_press(D, D, "min_press");
    do_press(10, 8, "short");
    do_press(LC - 1, 8, "just_short");
    do_press(LC, 8, "just_long");
    do_press(40, 8, "long");

    // Reset twelve cycles into a hold, key kept low throughout.
    p = edge_n + 2 + D;
    push_evt(p, K_RISE);
    $display("txn reset_mid_press: key low from cycle %0d, rst at hold 12", edge_n + 1);
    key = 1'b0;
    while (edge_n < p + 12) @(negedge clk);
    rst = 1'b1;
    e = edge_n + 1;
    push_evt(e, K_FALL);
    @(negedge clk);
    check_idle("reset_mid_press");
    rst = 1'b0;
    do_press(40, 10, "after_mid_reset");

    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(1, 45);
      gap = $urandom_range(D, D + 10);
      do_press(len, gap, "random");
    end

    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events never seen, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
